update_tick_receiver: RTL and testbench
=======================================

Name: update_tick_receiver

Overview:
- Receiving end of the toggle-style update ticks that the speed divider emits.
- Takes the free-running player and bullet update toggle levels and synchronizes them into this block's clock domain. Each toggle edge (rising or falling) counts as one update event.
- Events are queued per kind in saturating pending counters and released one at a time to the game-logic datapath over a valid/ready step handshake.
- Sits between the speed divider and the player/bullet position engines, so no tick is lost when the engines stall or both ticks arrive together.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per toggle input (legal 2..4)
PEND_W, 3, width of each pending-event counter; saturates at 2^PEND_W-1

Ports:
clk_i  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
player_update_i  in  1  player update toggle level; each edge = one event
bullet_update_i  in  1  bullet update toggle level; each edge = one event
step_ready_i  in  1  game logic accepts the offered step
step_valid_o  out  1  step offered
step_kind_o  out  1  0 = player step, 1 = bullet step; valid while step_valid_o=1
player_pending_o  out  PEND_W  queued player events
bullet_pending_o  out  PEND_W  queued bullet events
overrun_o  out  2  sticky saturation flags; bit0 = player, bit1 = bullet
clr_overrun_i  in  1  clears overrun_o

Behaviour:
Reset:
- Reset is asynchronous and active-low.
- Clock is clk_i, reset is rst_ni.
- While rst_ni=0: all sync flops, prev regs, pending counters, overrun_o, step_valid_o, step_kind_o and last_kind are 0, and the FSM is in IDLE.
- Reset mid-handshake drops the offered step and all pending events.

Synchronizer / edge detect:
- Each input passes through SYNC_STAGES flops. A prev reg holds the last synchronized value.
- event = sync_out XOR prev.
- Priming: for the first SYNC_STAGES+1 cycles after reset release, prev loads sync_out and events are suppressed. This prevents a spurious event when an input is already 1 at reset release.

Pending counters (independent per kind):
- Event only: +1.
- Step accepted for that kind only: -1.
- Event and accept in the same cycle: unchanged.
- Event while the counter is at max with no accept that cycle: counter holds at max and sets that kind's overrun_o bit.
- A counter never wraps and never underflows.

Overrun:
- Bits are sticky.
- clr_overrun_i=1 clears both bits, except that a new overrun in the same cycle wins: the bit stays 1.

Step FSM (IDLE, OFFER):
- IDLE: if exactly one counter is nonzero, latch that kind. If both are nonzero, latch the kind opposite to last_kind (round-robin). Go to OFFER; step_valid_o=1 from the next cycle.
- The kind is chosen from the counter values registered at the start of the IDLE cycle, before same-cycle events are applied.
- OFFER: step_valid_o=1 and step_kind_o are held stable until step_ready_i=1.
- On the accept cycle: decrement that kind's counter, update last_kind, return to IDLE; step_valid_o=0 the next cycle.
- Throughput: at most one step per 2 cycles.
- step_valid_o does not depend combinationally on step_ready_i.
- step_ready_i while in IDLE is ignored.

Latency:
- Idle block, counters 0, past priming, input toggled so the first sync flop captures it at edge E: player_pending_o=1 after edge E+SYNC_STAGES and step_valid_o=1 after edge E+SYNC_STAGES+1.
- Inputs are level toggles with a minimum stable time of SYNC_STAGES+1 cycles per level. Faster toggling is out of contract.

Outputs:
- All outputs are registered.
- player_pending_o and bullet_pending_o show the counter registers directly.

Test Plan:
All scenarios use SYNC_STAGES=2, PEND_W=3.
1. Reset release with both inputs held at 1, no toggles for 20 cycles, step_ready_i=1 -> step_valid_o stays 0, both pending 0, overrun_o=00.
2. Single player toggle 0->1 captured at edge E, step_ready_i=1 -> pending=1 after E+2, step_valid_o=1 with kind=0 after E+3, accepted same cycle, pending=0 and valid=0 one cycle later.
3. Both inputs toggle on the same edge, step_ready_i=1, last_kind=0 after reset -> steps issued in order bullet(1), then player(0), 2 cycles apart; both pending end at 0.
4. step_ready_i=0, 9 bullet toggles spaced 4 cycles apart -> bullet_pending_o stops at 7, overrun_o=10, valid stays 1 with kind stable. Pulse clr_overrun_i -> overrun_o=00. Raise ready -> 7 bullet steps issued, then idle.
5. Counter at 7 with step_ready_i=1 while a bullet event lands on the accept cycle -> count stays 7 and no overrun. Separately, with the counter at 7 and no accept, a bullet event and clr_overrun_i in the same cycle -> overrun_o[1]=1.
6. rst_ni asserted asynchronously mid-OFFER with pending=3 -> step_valid_o, pending and overrun drop to 0 immediately, without waiting for a clock edge. After release, priming suppresses events for 3 cycles.

Source files
------------

// File: rtl/update_tick_receiver.sv
// Receives the speed divider's toggle-style update ticks, queues player and
// bullet events in saturating counters and releases them one step at a time.
module update_tick_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              player_update_i,
    input  logic              bullet_update_i,
    input  logic              step_ready_i,
    output logic              step_valid_o,
    output logic              step_kind_o,
    output logic [PEND_W-1:0] player_pending_o,
    output logic [PEND_W-1:0] bullet_pending_o,
    output logic [1:0]        overrun_o,
    input  logic              clr_overrun_i
);

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
    localparam int PRIME_CYC = SYNC_STAGES + 1;
    localparam int PRIME_W   = $clog2(PRIME_CYC + 1);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_CYC);
    localparam logic [PRIME_W-1:0] PRIME_ONE  = PRIME_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } stepState_t;

    logic [SYNC_STAGES-1:0] r_playerSync;
    logic [SYNC_STAGES-1:0] r_bulletSync;
    logic                   r_playerPrev;
    logic                   r_bulletPrev;
    logic [PRIME_W-1:0]     r_primeCnt;
    logic [PEND_W-1:0]      r_playerPending;
    logic [PEND_W-1:0]      r_bulletPending;
    logic [1:0]             r_overrun;
    stepState_t             r_state;
    logic                   r_stepKind;
    logic                   r_lastKind;

    logic                   w_playerSyncOut;
    logic                   w_bulletSyncOut;
    logic                   w_primed;
    logic                   w_playerEvent;
    logic                   w_bulletEvent;
    logic                   w_accept;
    logic                   w_playerDec;
    logic                   w_bulletDec;
    logic [PEND_W:0]        w_playerUpd;
    logic [PEND_W:0]        w_bulletUpd;
    stepState_t             w_nextState;
    logic                   w_nextKind;

    // Returns {overrun, next count}; saturates at max and never underflows.
    function automatic logic [PEND_W:0] nextPending(
        input logic [PEND_W-1:0] cur,
        input logic              inc,
        input logic              dec
    );
        logic              ovr;
        logic [PEND_W-1:0] nxt;
        ovr = 1'b0;
        nxt = cur;
        if (inc && !dec) begin
            if (cur == PEND_MAX) begin
                ovr = 1'b1;
            end else begin
                nxt = cur + PEND_ONE;
            end
        end else if (dec && !inc && (cur != PEND_ZERO)) begin
            nxt = cur - PEND_ONE;
        end
        return {ovr, nxt};
    endfunction

    assign w_playerSyncOut = r_playerSync[SYNC_STAGES-1];
    assign w_bulletSyncOut = r_bulletSync[SYNC_STAGES-1];
    assign w_primed        = (r_primeCnt == PRIME_DONE);
    assign w_playerEvent   = w_primed && (w_playerSyncOut ^ r_playerPrev);
    assign w_bulletEvent   = w_primed && (w_bulletSyncOut ^ r_bulletPrev);

    assign w_accept    = (r_state == OFFER) && step_ready_i;
    assign w_playerDec = w_accept && !r_stepKind;
    assign w_bulletDec = w_accept && r_stepKind;

    assign w_playerUpd = nextPending(r_playerPending, w_playerEvent, w_playerDec);
    assign w_bulletUpd = nextPending(r_bulletPending, w_bulletEvent, w_bulletDec);

    // Prev regs track the synchronizer output every cycle, so once priming
    // ends they already hold the settled input level and no false edge fires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_playerSync <= '0;
            r_bulletSync <= '0;
            r_playerPrev <= 1'b0;
            r_bulletPrev <= 1'b0;
            r_primeCnt   <= '0;
        end else begin
            r_playerSync <= {r_playerSync[SYNC_STAGES-2:0], player_update_i};
            r_bulletSync <= {r_bulletSync[SYNC_STAGES-2:0], bullet_update_i};
            r_playerPrev <= w_playerSyncOut;
            r_bulletPrev <= w_bulletSyncOut;
            if (!w_primed) begin
                r_primeCnt <= r_primeCnt + PRIME_ONE;
            end
        end
    end

    // A fresh overrun beats a same-cycle clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_playerPending <= '0;
            r_bulletPending <= '0;
            r_overrun       <= 2'b00;
        end else begin
            r_playerPending <= w_playerUpd[PEND_W-1:0];
            r_bulletPending <= w_bulletUpd[PEND_W-1:0];
            r_overrun       <= (r_overrun & {2{~clr_overrun_i}})
                             | {w_bulletUpd[PEND_W], w_playerUpd[PEND_W]};
        end
    end

    // Kind selection uses the registered counts; ties go round-robin.
    always_comb begin
        w_nextState = r_state;
        w_nextKind  = r_stepKind;
        case (r_state)
            IDLE: begin
                if ((r_playerPending != PEND_ZERO) && (r_bulletPending != PEND_ZERO)) begin
                    w_nextState = OFFER;
                    w_nextKind  = ~r_lastKind;
                end else if (r_playerPending != PEND_ZERO) begin
                    w_nextState = OFFER;
                    w_nextKind  = 1'b0;
                end else if (r_bulletPending != PEND_ZERO) begin
                    w_nextState = OFFER;
                    w_nextKind  = 1'b1;
                end
            end
            OFFER: begin
                if (step_ready_i) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_stepKind <= 1'b0;
            r_lastKind <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_stepKind <= w_nextKind;
            if (w_accept) begin
                r_lastKind <= r_stepKind;
            end
        end
    end

    assign step_valid_o     = (r_state == OFFER);
    assign step_kind_o      = r_stepKind;
    assign player_pending_o = r_playerPending;
    assign bullet_pending_o = r_bulletPending;
    assign overrun_o        = r_overrun;

endmodule

// File: tb/tb_update_tick_receiver.sv
// Directed self-checking bench for update_tick_receiver (SYNC_STAGES=2, PEND_W=3).
module tb_update_tick_receiver;

    logic       clk_i;
    logic       rst_ni;
    logic       player_update_i;
    logic       bullet_update_i;
    logic       step_ready_i;
    logic       step_valid_o;
    logic       step_kind_o;
    logic [2:0] player_pending_o;
    logic [2:0] bullet_pending_o;
    logic [1:0] overrun_o;
    logic       clr_overrun_i;

    int assertCount = 0;
    int failCount   = 0;

    update_tick_receiver #(
        .SYNC_STAGES(2),
        .PEND_W(3)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .player_update_i(player_update_i),
        .bullet_update_i(bullet_update_i),
        .step_ready_i(step_ready_i),
        .step_valid_o(step_valid_o),
        .step_kind_o(step_kind_o),
        .player_pending_o(player_pending_o),
        .bullet_pending_o(bullet_pending_o),
        .overrun_o(overrun_o),
        .clr_overrun_i(clr_overrun_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        player_update_i = 1'b1;
        bullet_update_i = 1'b1;
        step_ready_i = 1'b1;
        clr_overrun_i = 1'b0;
        repeat (3) tick();
        assertCount++;
        if (step_valid_o !== 1'b0 || step_kind_o !== 1'b0 || player_pending_o !== 3'd0 ||
            bullet_pending_o !== 3'd0 || overrun_o !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL reset_state: got valid=%b kind=%b pp=%0d bp=%0d ovr=%b, expected all 0",
                     step_valid_o, step_kind_o, player_pending_o, bullet_pending_o, overrun_o);
        end
        #3 rst_ni = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            assertCount++;
            if (step_valid_o !== 1'b0 || player_pending_o !== 3'd0 || bullet_pending_o !== 3'd0 ||
                overrun_o !== 2'b00) begin
                failCount++;
                $display("[TB] FAIL prime_quiet cycle %0d: got valid=%b pp=%0d bp=%0d ovr=%b, expected 0 0 0 00",
                         i, step_valid_o, player_pending_o, bullet_pending_o, overrun_o);
            end
        end
    endtask

    task automatic test_single_player();
        step_ready_i = 1'b1;
        player_update_i = ~player_update_i;
        tick();
        tick();
        assertCount++;
        if (player_pending_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL single_lat_early: pp got %0d expected 0", player_pending_o);
        end
        tick();
        assertCount++;
        if (player_pending_o !== 3'd1 || step_valid_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_pending: got pp=%0d valid=%b expected pp=1 valid=0",
                     player_pending_o, step_valid_o);
        end
        tick();
        assertCount++;
        if (step_valid_o !== 1'b1 || step_kind_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_offer: got valid=%b kind=%b expected 1 0", step_valid_o, step_kind_o);
        end
        tick();
        assertCount++;
        if (step_valid_o !== 1'b0 || player_pending_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL single_accept: got valid=%b pp=%0d expected 0 0", step_valid_o, player_pending_o);
        end
        repeat (2) tick();
    endtask

    task automatic test_simultaneous();
        step_ready_i = 1'b1;
        player_update_i = ~player_update_i;
        bullet_update_i = ~bullet_update_i;
        repeat (3) tick();
        assertCount++;
        if (player_pending_o !== 3'd1 || bullet_pending_o !== 3'd1) begin
            failCount++;
            $display("[TB] FAIL simul_pending: got pp=%0d bp=%0d expected 1 1", player_pending_o, bullet_pending_o);
        end
        tick();
        assertCount++;
        if (step_valid_o !== 1'b1 || step_kind_o !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL simul_first: got valid=%b kind=%b expected 1 1 (bullet)", step_valid_o, step_kind_o);
        end
        tick();
        assertCount++;
        if (step_valid_o !== 1'b0 || bullet_pending_o !== 3'd0 || player_pending_o !== 3'd1) begin
            failCount++;
            $display("[TB] FAIL simul_gap: got valid=%b bp=%0d pp=%0d expected 0 0 1",
                     step_valid_o, bullet_pending_o, player_pending_o);
        end
        tick();
        assertCount++;
        if (step_valid_o !== 1'b1 || step_kind_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL simul_second: got valid=%b kind=%b expected 1 0 (player)", step_valid_o, step_kind_o);
        end
        tick();
        assertCount++;
        if (step_valid_o !== 1'b0 || player_pending_o !== 3'd0 || bullet_pending_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL simul_done: got valid=%b pp=%0d bp=%0d expected 0 0 0",
                     step_valid_o, player_pending_o, bullet_pending_o);
        end
        repeat (2) tick();
    endtask

    task automatic test_saturation();
        int accepts;
        step_ready_i = 1'b0;
        for (int i = 0; i < 9; i++) begin
            bullet_update_i = ~bullet_update_i;
            repeat (4) tick();
        end
        assertCount++;
        if (bullet_pending_o !== 3'd7 || overrun_o !== 2'b10 || step_valid_o !== 1'b1 ||
            step_kind_o !== 1'b1 || player_pending_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL sat_state: got bp=%0d ovr=%b valid=%b kind=%b pp=%0d expected 7 10 1 1 0",
                     bullet_pending_o, overrun_o, step_valid_o, step_kind_o, player_pending_o);
        end
        clr_overrun_i = 1'b1;
        tick();
        clr_overrun_i = 1'b0;
        assertCount++;
        if (overrun_o !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL sat_clear: got ovr=%b expected 00", overrun_o);
        end
        step_ready_i = 1'b1;
        accepts = 0;
        for (int i = 0; i < 20; i++) begin
            if (step_valid_o === 1'b1) begin
                accepts++;
                assertCount++;
                if (step_kind_o !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL sat_drain_kind: got kind=%b expected 1", step_kind_o);
                end
            end
            tick();
        end
        step_ready_i = 1'b0;
        assertCount++;
        if (accepts != 7 || bullet_pending_o !== 3'd0 || step_valid_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL sat_drain: got accepts=%0d bp=%0d valid=%b expected 7 0 0",
                     accepts, bullet_pending_o, step_valid_o);
        end
    endtask

    task automatic test_accept_at_max();
        step_ready_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bullet_update_i = ~bullet_update_i;
            repeat (4) tick();
        end
        assertCount++;
        if (bullet_pending_o !== 3'd7 || overrun_o !== 2'b00 || step_valid_o !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL max_fill: got bp=%0d ovr=%b valid=%b expected 7 00 1",
                     bullet_pending_o, overrun_o, step_valid_o);
        end
        bullet_update_i = ~bullet_update_i;
        tick();
        tick();
        step_ready_i = 1'b1;
        tick();
        step_ready_i = 1'b0;
        assertCount++;
        if (bullet_pending_o !== 3'd7 || overrun_o !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL max_event_accept: got bp=%0d ovr=%b expected 7 00", bullet_pending_o, overrun_o);
        end
        repeat (2) tick();
        bullet_update_i = ~bullet_update_i;
        tick();
        tick();
        clr_overrun_i = 1'b1;
        tick();
        clr_overrun_i = 1'b0;
        assertCount++;
        if (overrun_o !== 2'b10 || bullet_pending_o !== 3'd7) begin
            failCount++;
            $display("[TB] FAIL max_ovr_beats_clr: got ovr=%b bp=%0d expected 10 7", overrun_o, bullet_pending_o);
        end
    endtask

    task automatic test_async_reset();
        step_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            player_update_i = ~player_update_i;
            repeat (4) tick();
        end
        assertCount++;
        if (player_pending_o !== 3'd3 || step_valid_o !== 1'b1 || overrun_o !== 2'b10) begin
            failCount++;
            $display("[TB] FAIL pre_reset: got pp=%0d valid=%b ovr=%b expected 3 1 10",
                     player_pending_o, step_valid_o, overrun_o);
        end
        #3 rst_ni = 1'b0;
        #1;
        assertCount++;
        if (step_valid_o !== 1'b0 || player_pending_o !== 3'd0 || bullet_pending_o !== 3'd0 ||
            overrun_o !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL async_reset: got valid=%b pp=%0d bp=%0d ovr=%b expected 0 0 0 00",
                     step_valid_o, player_pending_o, bullet_pending_o, overrun_o);
        end
        player_update_i = 1'b1;
        bullet_update_i = 1'b1;
        repeat (2) tick();
        #3 rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            assertCount++;
            if (step_valid_o !== 1'b0 || player_pending_o !== 3'd0 || bullet_pending_o !== 3'd0) begin
                failCount++;
                $display("[TB] FAIL reprime cycle %0d: got valid=%b pp=%0d bp=%0d expected 0 0 0",
                         i, step_valid_o, player_pending_o, bullet_pending_o);
            end
        end
        player_update_i = ~player_update_i;
        repeat (3) tick();
        assertCount++;
        if (player_pending_o !== 3'd1 || bullet_pending_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL post_prime_event: got pp=%0d bp=%0d expected 1 0", player_pending_o, bullet_pending_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_player();
        test_simultaneous();
        test_saturation();
        test_accept_at_max();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
